// File: rtl/forwarding.sv
// Result bypass record published by a stage's output register.
package forwarding;
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        data_valid;
    } t;
endpackage

// File: rtl/instruction.sv
// Decoded instruction as carried between pipeline stages.
package instruction;
    typedef enum logic [3:0] {NOP, ADD, LB, LH, LW, LBU, LHU, SB, SH, SW} op_e;

    typedef struct packed {
        op_e        op;
        logic [4:0] rd;
    } t;

    localparam t NOP_INSN = '{op: NOP, rd: 5'd0};
endpackage

// File: rtl/memory_stage_pkg.sv
// Load/store width decode shared by the memory stage and its lane aligner.
package memory_stage_pkg;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    function automatic logic is_load(input instruction::op_e op);
        return op inside {instruction::LB, instruction::LH, instruction::LW,
                          instruction::LBU, instruction::LHU};
    endfunction

    function automatic logic is_store(input instruction::op_e op);
        return op inside {instruction::SB, instruction::SH, instruction::SW};
    endfunction

    function automatic logic is_unsigned(input instruction::op_e op);
        return op inside {instruction::LBU, instruction::LHU};
    endfunction

    function automatic logic writes_rd(input instruction::op_e op);
        return (op == instruction::ADD) || is_load(op);
    endfunction

    function automatic size_e access_size(input instruction::op_e op);
        case (op)
            instruction::LB, instruction::LBU, instruction::SB: return SZ_B;
            instruction::LH, instruction::LHU, instruction::SH: return SZ_H;
            default:                                            return SZ_W;
        endcase
    endfunction

    function automatic logic misaligned(input instruction::op_e op, input logic [1:0] lane);
        case (access_size(op))
            SZ_H:    return lane[0];
            SZ_W:    return lane != 2'b00;
            default: return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/pipeline_status.sv
// Handshake status travelling down (forwards) and up (backwards) the pipeline.
package pipeline_status;
    typedef enum logic [2:0] {BUBBLE, VALID, LOAD_MISALIGNED, STORE_MISALIGNED, ILLEGAL} forwards_t;
    typedef enum logic [1:0] {READY, STALL, JUMP} backwards_t;
endpackage

// File: rtl/load_store_align.sv
// Byte-lane steering: store replication/strobes and load extraction/extension.
module load_store_align
    import memory_stage_pkg::*;
(
    input  instruction::op_e op,
    input  logic [1:0]       lane,
    input  logic [31:0]      src,
    input  logic [31:0]      rdata,
    output logic [31:0]      wdata,
    output logic [3:0]       wstrb,
    output logic [31:0]      load_data
);
    logic [31:0] shifted;

    always_comb begin
        shifted   = rdata >> {lane, 3'b000};
        wdata     = src;
        wstrb     = 4'b1111;
        load_data = shifted;
        case (access_size(op))
            SZ_B: begin
                wdata     = {4{src[7:0]}};
                wstrb     = 4'b0001 << lane;
                load_data = is_unsigned(op) ? {24'd0, shifted[7:0]}
                                            : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                wdata     = {2{src[15:0]}};
                wstrb     = 4'b0011 << lane;
                load_data = is_unsigned(op) ? {16'd0, shifted[15:0]}
                                            : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues data-bus loads/stores, stalls until ack,
// and registers the result for writeback.
module memory_stage
    import memory_stage_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  source_data_in,
    input  logic [31:0]                  rd_data_in,
    input  instruction::t                instruction_in,
    input  logic [31:0]                  program_counter_in,
    input  logic [31:0]                  next_program_counter_in,
    output logic                         dmem_req_out,
    output logic                         dmem_we_out,
    output logic [31:0]                  dmem_addr_out,
    output logic [31:0]                  dmem_wdata_out,
    output logic [3:0]                   dmem_wstrb_out,
    input  logic                         dmem_ack_in,
    input  logic [31:0]                  dmem_rdata_in,
    output logic [31:0]                  source_data_out,
    output logic [31:0]                  rd_data_out,
    output instruction::t                instruction_out,
    output logic [31:0]                  program_counter_out,
    output logic [31:0]                  next_program_counter_out,
    output forwarding::t                 forwarding_out,
    input  pipeline_status::forwards_t   status_forwards_in,
    output pipeline_status::forwards_t   status_forwards_out,
    input  pipeline_status::backwards_t  status_backwards_in,
    output pipeline_status::backwards_t  status_backwards_out,
    input  logic [31:0]                  jump_address_backwards_in,
    output logic [31:0]                  jump_address_backwards_out
);
    typedef enum logic {IDLE, WAIT_ACK} state_e;

    state_e                     state_q, state_d;
    logic                       jumped_q, jumped_d;
    logic [31:0]                pend_src_q, pend_src_d, pend_addr_q, pend_addr_d;
    logic [31:0]                pend_pc_q, pend_pc_d, pend_npc_q, pend_npc_d;
    instruction::t              pend_insn_q, pend_insn_d;
    logic [31:0]                src_q, src_d, rd_q, rd_d, pc_q, pc_d, npc_q, npc_d;
    instruction::t              insn_q, insn_d;
    pipeline_status::forwards_t stat_q, stat_d;

    logic             idle, go, is_jump, in_valid, in_mem, in_misal, start, busy, acc_store, bubble;
    instruction::op_e acc_op;
    logic [31:0]      acc_addr, acc_src, wdata, load_data;
    logic [3:0]       wstrb;

    // Once waiting, the access is replayed from the pending copy so a flushed
    // upstream cannot disturb the bus signals.
    always_comb begin
        idle      = state_q == IDLE;
        is_jump   = status_backwards_in == pipeline_status::JUMP;
        go        = status_backwards_in == pipeline_status::READY;
        in_valid  = status_forwards_in == pipeline_status::VALID;
        in_mem    = is_load(instruction_in.op) || is_store(instruction_in.op);
        in_misal  = misaligned(instruction_in.op, rd_data_in[1:0]);
        start     = idle && go && in_valid && in_mem && !in_misal;
        busy      = !rst && (start || !idle);
        acc_op    = idle ? instruction_in.op : pend_insn_q.op;
        acc_addr  = idle ? rd_data_in : pend_addr_q;
        acc_src   = idle ? source_data_in : pend_src_q;
        acc_store = is_store(acc_op);
    end

    load_store_align u_align (
        .op        (acc_op),
        .lane      (acc_addr[1:0]),
        .src       (acc_src),
        .rdata     (dmem_rdata_in),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .load_data (load_data)
    );

    assign dmem_req_out               = busy;
    assign dmem_we_out                = busy && acc_store;
    assign dmem_addr_out              = busy ? {acc_addr[31:2], 2'b00} : 32'd0;
    assign dmem_wdata_out             = (busy && acc_store) ? wdata : 32'd0;
    assign dmem_wstrb_out             = (busy && acc_store) ? wstrb : 4'd0;
    assign jump_address_backwards_out = jump_address_backwards_in;

    always_comb begin
        status_backwards_out = status_backwards_in;
        if (!is_jump && busy && !dmem_ack_in) status_backwards_out = pipeline_status::STALL;
    end

    always_comb begin
        state_d     = state_q;
        jumped_d    = jumped_q;
        pend_src_d  = pend_src_q;
        pend_addr_d = pend_addr_q;
        pend_pc_d   = pend_pc_q;
        pend_npc_d  = pend_npc_q;
        pend_insn_d = pend_insn_q;
        src_d       = src_q;
        rd_d        = rd_q;
        pc_d        = pc_q;
        npc_d       = npc_q;
        insn_d      = insn_q;
        stat_d      = stat_q;
        bubble      = 1'b0;
        if (idle) begin
            if (is_jump) begin
                bubble = 1'b1;
            end else if (go) begin
                src_d  = source_data_in;
                rd_d   = rd_data_in;
                pc_d   = program_counter_in;
                npc_d  = next_program_counter_in;
                insn_d = instruction_in;
                stat_d = status_forwards_in;
                if (in_valid && in_mem) begin
                    if (in_misal) begin
                        stat_d = is_load(instruction_in.op) ? pipeline_status::LOAD_MISALIGNED
                                                            : pipeline_status::STORE_MISALIGNED;
                    end else if (dmem_ack_in) begin
                        if (is_load(instruction_in.op)) rd_d = load_data;
                    end else begin
                        bubble      = 1'b1;
                        state_d     = WAIT_ACK;
                        jumped_d    = 1'b0;
                        pend_src_d  = source_data_in;
                        pend_addr_d = rd_data_in;
                        pend_pc_d   = program_counter_in;
                        pend_npc_d  = next_program_counter_in;
                        pend_insn_d = instruction_in;
                    end
                end
            end
        end else begin
            if (is_jump) jumped_d = 1'b1;
            // The output register only holds a bubble while waiting, so the
            // result may land even if downstream is stalled.
            if (dmem_ack_in) begin
                state_d = IDLE;
                if (jumped_d) begin
                    bubble = 1'b1;
                end else begin
                    src_d  = pend_src_q;
                    rd_d   = is_load(pend_insn_q.op) ? load_data : pend_addr_q;
                    pc_d   = pend_pc_q;
                    npc_d  = pend_npc_q;
                    insn_d = pend_insn_q;
                    stat_d = pipeline_status::VALID;
                end
            end
        end
        if (bubble) begin
            src_d  = 32'd0;
            rd_d   = 32'd0;
            pc_d   = 32'd0;
            npc_d  = 32'd0;
            insn_d = instruction::NOP_INSN;
            stat_d = pipeline_status::BUBBLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            jumped_q    <= 1'b0;
            pend_src_q  <= 32'd0;
            pend_addr_q <= 32'd0;
            pend_pc_q   <= 32'd0;
            pend_npc_q  <= 32'd0;
            pend_insn_q <= instruction::NOP_INSN;
            src_q       <= 32'd0;
            rd_q        <= 32'd0;
            pc_q        <= 32'd0;
            npc_q       <= 32'd0;
            insn_q      <= instruction::NOP_INSN;
            stat_q      <= pipeline_status::BUBBLE;
        end else begin
            state_q     <= state_d;
            jumped_q    <= jumped_d;
            pend_src_q  <= pend_src_d;
            pend_addr_q <= pend_addr_d;
            pend_pc_q   <= pend_pc_d;
            pend_npc_q  <= pend_npc_d;
            pend_insn_q <= pend_insn_d;
            src_q       <= src_d;
            rd_q        <= rd_d;
            pc_q        <= pc_d;
            npc_q       <= npc_d;
            insn_q      <= insn_d;
            stat_q      <= stat_d;
        end
    end

    assign source_data_out           = src_q;
    assign rd_data_out               = rd_q;
    assign instruction_out           = insn_q;
    assign program_counter_out       = pc_q;
    assign next_program_counter_out  = npc_q;
    assign status_forwards_out       = stat_q;
    assign forwarding_out.rd         = insn_q.rd;
    assign forwarding_out.data       = rd_q;
    assign forwarding_out.data_valid = (stat_q == pipeline_status::VALID) && writes_rd(insn_q.op)
                                       && (insn_q.rd != 5'd0) && idle;
endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: ALU pass-through, loads, stores,
// misalignment, stall/jump handling and reset during an outstanding access.
module tb_memory_stage;
    logic                        clk = 1'b0;
    logic                        rst;
    logic [31:0]                 source_data_in, rd_data_in, pc_in, npc_in;
    instruction::t               instruction_in;
    logic                        dmem_req_out, dmem_we_out, dmem_ack_in;
    logic [31:0]                 dmem_addr_out, dmem_wdata_out, dmem_rdata_in;
    logic [3:0]                  dmem_wstrb_out;
    logic [31:0]                 source_data_out, rd_data_out, pc_out, npc_out;
    instruction::t               instruction_out;
    forwarding::t                fwd;
    pipeline_status::forwards_t  sf_in, sf_out;
    pipeline_status::backwards_t sb_in, sb_out;
    logic [31:0]                 jaddr_in, jaddr_out;

    int n_assert = 0;
    int n_fail   = 0;

    memory_stage dut (
        .clk                        (clk),
        .rst                        (rst),
        .source_data_in             (source_data_in),
        .rd_data_in                 (rd_data_in),
        .instruction_in             (instruction_in),
        .program_counter_in         (pc_in),
        .next_program_counter_in    (npc_in),
        .dmem_req_out               (dmem_req_out),
        .dmem_we_out                (dmem_we_out),
        .dmem_addr_out              (dmem_addr_out),
        .dmem_wdata_out             (dmem_wdata_out),
        .dmem_wstrb_out             (dmem_wstrb_out),
        .dmem_ack_in                (dmem_ack_in),
        .dmem_rdata_in              (dmem_rdata_in),
        .source_data_out            (source_data_out),
        .rd_data_out                (rd_data_out),
        .instruction_out            (instruction_out),
        .program_counter_out        (pc_out),
        .next_program_counter_out   (npc_out),
        .forwarding_out             (fwd),
        .status_forwards_in         (sf_in),
        .status_forwards_out        (sf_out),
        .status_backwards_in        (sb_in),
        .status_backwards_out       (sb_out),
        .jump_address_backwards_in  (jaddr_in),
        .jump_address_backwards_out (jaddr_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected $finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input instruction::op_e op, input logic [4:0] rd, input logic [31:0] src,
                         input logic [31:0] rdv, input pipeline_status::forwards_t st);
        instruction_in.op = op;
        instruction_in.rd = rd;
        source_data_in    = src;
        rd_data_in        = rdv;
        sf_in             = st;
    endtask

    initial begin
        rst = 1'b1;
        drive(instruction::NOP, 5'd0, 32'd0, 32'd0, pipeline_status::BUBBLE);
        pc_in = 32'd0; npc_in = 32'd0; jaddr_in = 32'd0;
        sb_in = pipeline_status::READY; dmem_ack_in = 1'b0; dmem_rdata_in = 32'd0;
        #2;
        chk("rst_req", 32'(dmem_req_out), 32'd0);
        chk("rst_wstrb", 32'(dmem_wstrb_out), 32'd0);
        chk("rst_rd", rd_data_out, 32'd0);
        chk("rst_stat", 32'(sf_out), 32'(pipeline_status::BUBBLE));
        chk("rst_insn", 32'(instruction_out.op), 32'(instruction::NOP));
        chk("rst_fwd", 32'(fwd.data_valid), 32'd0);

        // ADD x5 = 0x1234
        @(negedge clk); rst = 1'b0;
        drive(instruction::ADD, 5'd5, 32'd0, 32'h1234, pipeline_status::VALID);
        pc_in = 32'h100; npc_in = 32'h104;
        #1 chk("add_req", 32'(dmem_req_out), 32'd0);
        chk("add_bw", 32'(sb_out), 32'(pipeline_status::READY));
        @(posedge clk); #1;
        chk("add_rd", rd_data_out, 32'h1234);
        chk("add_stat", 32'(sf_out), 32'(pipeline_status::VALID));
        chk("add_pc", pc_out, 32'h100);
        chk("add_npc", npc_out, 32'h104);
        chk("add_fwd_v", 32'(fwd.data_valid), 32'd1);
        chk("add_fwd_rd", 32'(fwd.rd), 32'd5);

        // LB at 0x103, ack after 3 stall cycles
        @(negedge clk);
        drive(instruction::LB, 5'd6, 32'd0, 32'h103, pipeline_status::VALID);
        #1 chk("lb_req", 32'(dmem_req_out), 32'd1);
        chk("lb_addr", dmem_addr_out, 32'h100);
        chk("lb_we", 32'(dmem_we_out), 32'd0);
        chk("lb_stall0", 32'(sb_out), 32'(pipeline_status::STALL));
        for (int i = 1; i < 3; i++) begin
            @(negedge clk); #1;
            chk("lb_stall", 32'(sb_out), 32'(pipeline_status::STALL));
            chk("lb_req_hold", 32'(dmem_req_out), 32'd1);
            chk("lb_fwd_wait", 32'(fwd.data_valid), 32'd0);
            chk("lb_stat_wait", 32'(sf_out), 32'(pipeline_status::BUBBLE));
        end
        @(negedge clk); dmem_ack_in = 1'b1; dmem_rdata_in = 32'h80FFFFFF;
        #1 chk("lb_ack_bw", 32'(sb_out), 32'(pipeline_status::READY));
        @(posedge clk); #1;
        chk("lb_rd", rd_data_out, 32'hFFFFFF80);
        chk("lb_stat", 32'(sf_out), 32'(pipeline_status::VALID));
        chk("lb_fwd_v", 32'(fwd.data_valid), 32'd1);
        @(negedge clk); dmem_ack_in = 1'b0; sf_in = pipeline_status::BUBBLE;
        #1 chk("lb_req_drop", 32'(dmem_req_out), 32'd0);

        // LBU at 0x103 with ack in the request cycle
        @(negedge clk);
        drive(instruction::LBU, 5'd7, 32'd0, 32'h103, pipeline_status::VALID);
        dmem_ack_in = 1'b1; dmem_rdata_in = 32'h80FFFFFF;
        #1 chk("lbu_req", 32'(dmem_req_out), 32'd1);
        chk("lbu_bw", 32'(sb_out), 32'(pipeline_status::READY));
        @(posedge clk); #1;
        chk("lbu_rd", rd_data_out, 32'h00000080);
        chk("lbu_stat", 32'(sf_out), 32'(pipeline_status::VALID));

        // SH 0xABCD at 0x202, ack one cycle later
        @(negedge clk); dmem_ack_in = 1'b0;
        drive(instruction::SH, 5'd0, 32'h0000ABCD, 32'h202, pipeline_status::VALID);
        #1 chk("sh_addr", dmem_addr_out, 32'h200);
        chk("sh_wstrb", 32'(dmem_wstrb_out), 32'hC);
        chk("sh_wdata", dmem_wdata_out, 32'hABCDABCD);
        chk("sh_we", 32'(dmem_we_out), 32'd1);
        @(negedge clk); #1;
        chk("sh_we_hold", 32'(dmem_we_out), 32'd1);
        chk("sh_addr_hold", dmem_addr_out, 32'h200);
        dmem_ack_in = 1'b1;
        @(posedge clk); #1;
        chk("sh_stat", 32'(sf_out), 32'(pipeline_status::VALID));
        chk("sh_fwd_v", 32'(fwd.data_valid), 32'd0);
        chk("sh_insn", 32'(instruction_out.op), 32'(instruction::SH));
        @(negedge clk); dmem_ack_in = 1'b0; sf_in = pipeline_status::BUBBLE;
        #1 chk("sh_we_drop", 32'(dmem_we_out), 32'd0);
        chk("sh_wstrb_drop", 32'(dmem_wstrb_out), 32'd0);

        // SB at 0x003: top lane
        @(negedge clk);
        drive(instruction::SB, 5'd0, 32'h1234565A, 32'h3, pipeline_status::VALID);
        dmem_ack_in = 1'b1;
        #1 chk("sb_wstrb", 32'(dmem_wstrb_out), 32'h8);
        chk("sb_wdata", dmem_wdata_out, 32'h5A5A5A5A);
        chk("sb_addr", dmem_addr_out, 32'h0);

        // Misaligned LW / SH
        @(negedge clk); dmem_ack_in = 1'b0;
        drive(instruction::LW, 5'd8, 32'd0, 32'h101, pipeline_status::VALID);
        #1 chk("lw_mis_req", 32'(dmem_req_out), 32'd0);
        @(posedge clk); #1;
        chk("lw_mis_stat", 32'(sf_out), 32'(pipeline_status::LOAD_MISALIGNED));
        chk("lw_mis_rd", rd_data_out, 32'h101);
        @(negedge clk);
        drive(instruction::SH, 5'd0, 32'h1, 32'h201, pipeline_status::VALID);
        #1 chk("sh_mis_req", 32'(dmem_req_out), 32'd0);
        @(posedge clk); #1;
        chk("sh_mis_stat", 32'(sf_out), 32'(pipeline_status::STORE_MISALIGNED));

        // Non-VALID status passes through without a bus access
        @(negedge clk);
        drive(instruction::LB, 5'd9, 32'd0, 32'h100, pipeline_status::ILLEGAL);
        #1 chk("ill_req", 32'(dmem_req_out), 32'd0);
        @(posedge clk); #1;
        chk("ill_stat", 32'(sf_out), 32'(pipeline_status::ILLEGAL));

        // Downstream STALL: no access, output held
        @(negedge clk);
        drive(instruction::LB, 5'd9, 32'd0, 32'h100, pipeline_status::VALID);
        sb_in = pipeline_status::STALL;
        #1 chk("stl_req", 32'(dmem_req_out), 32'd0);
        chk("stl_bw", 32'(sb_out), 32'(pipeline_status::STALL));
        @(posedge clk); #1;
        chk("stl_hold", 32'(sf_out), 32'(pipeline_status::ILLEGAL));

        // JUMP while idle
        @(negedge clk);
        drive(instruction::ADD, 5'd3, 32'd0, 32'h55, pipeline_status::VALID);
        sb_in = pipeline_status::JUMP; jaddr_in = 32'hDEAD0000;
        #1 chk("jmp_bw", 32'(sb_out), 32'(pipeline_status::JUMP));
        chk("jmp_addr", jaddr_out, 32'hDEAD0000);
        @(posedge clk); #1;
        chk("jmp_stat", 32'(sf_out), 32'(pipeline_status::BUBBLE));
        chk("jmp_insn", 32'(instruction_out.op), 32'(instruction::NOP));

        // JUMP during WAIT_ACK
        @(negedge clk); sb_in = pipeline_status::READY;
        drive(instruction::LW, 5'd10, 32'd0, 32'h300, pipeline_status::VALID);
        #1 chk("jw_req", 32'(dmem_req_out), 32'd1);
        @(negedge clk); sb_in = pipeline_status::JUMP; jaddr_in = 32'h4000;
        #1 chk("jw_req_hold", 32'(dmem_req_out), 32'd1);
        chk("jw_bw", 32'(sb_out), 32'(pipeline_status::JUMP));
        chk("jw_addr", jaddr_out, 32'h4000);
        @(negedge clk); sb_in = pipeline_status::READY;
        drive(instruction::NOP, 5'd0, 32'd0, 32'd0, pipeline_status::BUBBLE);
        #1 chk("jw_req_kept", 32'(dmem_req_out), 32'd1);
        chk("jw_bus_addr", dmem_addr_out, 32'h300);
        chk("jw_stall", 32'(sb_out), 32'(pipeline_status::STALL));
        dmem_ack_in = 1'b1; dmem_rdata_in = 32'h12345678;
        @(posedge clk); #1;
        chk("jw_stat", 32'(sf_out), 32'(pipeline_status::BUBBLE));
        chk("jw_rd", rd_data_out, 32'd0);
        chk("jw_fwd", 32'(fwd.data_valid), 32'd0);
        @(negedge clk); dmem_ack_in = 1'b0;
        #1 chk("jw_req_drop", 32'(dmem_req_out), 32'd0);

        // Reset during WAIT_ACK; late ack ignored
        @(negedge clk);
        drive(instruction::LW, 5'd11, 32'd0, 32'h400, pipeline_status::VALID);
        @(negedge clk); sf_in = pipeline_status::BUBBLE;
        #1 chk("rw_req", 32'(dmem_req_out), 32'd1);
        chk("rw_addr", dmem_addr_out, 32'h400);
        #1 rst = 1'b1;
        #1 chk("rw_req_drop", 32'(dmem_req_out), 32'd0);
        chk("rw_stat", 32'(sf_out), 32'(pipeline_status::BUBBLE));
        @(negedge clk); rst = 1'b0; dmem_ack_in = 1'b1;
        @(posedge clk); #1;
        chk("rw_late_req", 32'(dmem_req_out), 32'd0);
        chk("rw_late_stat", 32'(sf_out), 32'(pipeline_status::BUBBLE));
        @(negedge clk); dmem_ack_in = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 SHALL have the following ports: clk in 1 (rising-edge clock); rst in 1 (asynchronous, active-high reset).
REQ-002 SHALL have upstream inputs: source_data_in in 32 (rs2 value); rd_data_in in 32 (ALU result or effective address); instruction_in in instruction::t; program_counter_in in 32; next_program_counter_in in 32.
REQ-003 SHALL have data-bus ports: dmem_req_out out 1; dmem_we_out out 1; dmem_addr_out out 32 (word-aligned); dmem_wdata_out out 32; dmem_wstrb_out out 4; dmem_ack_in in 1; dmem_rdata_in in 32.
REQ-004 SHALL have downstream outputs to writeback_stage, all registered: source_data_out 32; rd_data_out 32; instruction_out instruction::t; program_counter_out 32; next_program_counter_out 32.
REQ-005 SHALL have forwarding_out out forwarding::t, carrying the rd index, data and data-valid flag of the output register.
REQ-006 SHALL have pipeline-control ports: status_forwards_in in pipeline_status::forwards_t; status_forwards_out out pipeline_status::forwards_t; status_backwards_in in pipeline_status::backwards_t; status_backwards_out out pipeline_status::backwards_t; jump_address_backwards_in in 32; jump_address_backwards_out out 32.

Function
REQ-007 SHALL use a two-state FSM: IDLE and WAIT_ACK.
REQ-008 Non-memory instruction, input VALID, status_backwards_in READY: SHALL register all inputs unchanged with 1-cycle latency and present status_forwards_out VALID.
REQ-009 Valid load/store in IDLE: SHALL assert dmem_req_out combinationally in the same cycle, hold addr/we/wdata/wstrb stable, and go to WAIT_ACK if dmem_ack_in is low.
REQ-010 SHALL drive status_backwards_out STALL while a bus access is outstanding (request asserted and dmem_ack_in low) or while status_backwards_in is STALL; otherwise it SHALL pass status_backwards_in through.
REQ-011 On the dmem_ack_in cycle the stage SHALL drop dmem_req_out in the next cycle, return to IDLE, and register the result; ack in the request cycle gives 1-cycle latency.
REQ-012 Loads SHALL use byte lane = addr[1:0]; LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend; LW SHALL take all 32 bits; the result SHALL replace rd_data_out.
REQ-013 Stores SHALL replicate the byte/half of source_data_in into the addressed lane; wstrb SHALL be SB 0001<<addr[1:0], SH 0011<<addr[1:0], SW 1111.
REQ-014 Half access at addr[0]=1 or word access at addr[1:0]!=0 SHALL issue no bus request and SHALL register status_forwards_out LOAD_MISALIGNED or STORE_MISALIGNED in 1 cycle.
REQ-015 status_forwards_in BUBBLE or any non-VALID status SHALL produce no bus request and SHALL propagate that status unchanged.
REQ-016 status_backwards_in STALL SHALL hold the output register and SHALL NOT start a new bus access.
REQ-017 status_backwards_in JUMP SHALL pass JUMP and jump_address_backwards_in through combinationally and SHALL load BUBBLE into the output register.
REQ-018 A JUMP during WAIT_ACK SHALL NOT abandon the access: the stage SHALL hold the request until ack, discard the data, and emit BUBBLE.
REQ-019 forwarding_out data-valid SHALL be 1 only for a VALID output register whose instruction writes rd!=0; it SHALL be 0 during WAIT_ACK.

Reset
REQ-020 rst SHALL asynchronously force: FSM IDLE; dmem_req_out/we 0; wstrb 0; all data outputs 0; instruction_out NOP; status_forwards_out BUBBLE; forwarding data-valid 0.
REQ-021 Reset during WAIT_ACK SHALL drop the request immediately, and an ack arriving after reset SHALL be ignored.

Structure
REQ-022 Load/store width decode and the forwarding::t, pipeline_status and instruction::t types SHALL live in the shared packages; no new local typedefs except the FSM enum.
REQ-023 Lane alignment/extension SHALL be a combinational sub-module named load_store_align.

Verification
REQ-024 ADD x5 (result 0x1234) with READY downstream -> rd_data_out=0x1234 and VALID one cycle later, with no dmem_req_out.
REQ-025 LB at 0x103 with rdata 0x80FFFFFF and ack after 3 cycles -> STALL for 3 cycles, then rd_data_out=0xFFFFFF80; LBU gives 0x00000080.
REQ-026 SH of 0xABCD at 0x202 -> dmem_addr_out=0x200, wstrb=1100, wdata=0xABCDABCD, and dmem_we_out=1 until ack.
REQ-027 LW at 0x101 -> no request and LOAD_MISALIGNED registered next cycle.
REQ-028 JUMP arriving in WAIT_ACK -> request held until ack, output BUBBLE, and jump address passed through.
REQ-029 rst asserted in WAIT_ACK -> dmem_req_out falls asynchronously and the output is BUBBLE.
